// File: rtl/mor1kx_pic_vectored_if.sv
// SPR bus bundle between the mor1kx control unit (master) and the PIC (slave).
// Access-to-ack is zero latency, so no handshake state lives here.
interface mor1kx_pic_vectored_if;
  logic        spr_access_i;
  logic        spr_we_i;
  logic [15:0] spr_addr_i;
  logic [31:0] spr_dat_i;
  logic        spr_bus_ack;
  logic [31:0] spr_dat_o;

  modport master (
    output spr_access_i, spr_we_i, spr_addr_i, spr_dat_i,
    input  spr_bus_ack, spr_dat_o
  );

  modport slave (
    input  spr_access_i, spr_we_i, spr_addr_i, spr_dat_i,
    output spr_bus_ack, spr_dat_o
  );
endinterface

// File: rtl/mor1kx_pic_vectored.sv
// Vectored PIC for mor1kx: per-line level/edge trigger, optional input synchroniser,
// PICMR/PICSR/PICID on the SPR bus and a registered lowest-index-wins interrupt vector.
module mor1kx_pic_vectored #(
  parameter int          NUM_IRQS             = 32,
  parameter int          OPTION_PIC_NMI_WIDTH = 0,
  parameter logic [31:0] EDGE_MASK            = 32'h0,
  parameter int          SYNC_STAGES          = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 irq_i,
  mor1kx_pic_vectored_if.slave        spr,
  output logic [31:0]                 spr_picmr_o,
  output logic [31:0]                 spr_picsr_o,
  output logic                        irq_o,
  output logic [4:0]                  irq_id_o
);

  function automatic logic [31:0] low_ones(input int n);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++)
      if (i < n) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [4:0] lowest_set(input logic [31:0] v);
    logic [4:0] id;
    id = '0;
    for (int i = 31; i >= 0; i--)
      if (v[i]) id = 5'(i);
    return id;
  endfunction

  localparam logic [31:0] IMPL_MASK  = low_ones(NUM_IRQS);
  localparam logic [31:0] NMI_MASK   = low_ones(OPTION_PIC_NMI_WIDTH) & IMPL_MASK;
  localparam logic [31:0] EDGE_BITS  = EDGE_MASK & IMPL_MASK;
  localparam logic [31:0] LEVEL_BITS = ~EDGE_MASK & IMPL_MASK;

  localparam logic [10:0] OFF_PICMR = 11'd0;
  localparam logic [10:0] OFF_PICID = 11'd1;
  localparam logic [10:0] OFF_PICSR = 11'd2;

  logic [31:0] w_sync;
  logic [31:0] w_edge;
  logic [31:0] w_picsr;
  logic [31:0] w_clr;
  logic [10:0] w_offset;
  logic        w_wr_picmr;
  logic        w_wr_picsr;
  logic        w_unused;

  logic [31:0] r_picmr;
  logic [31:0] r_edge_hist;
  logic [31:0] r_picsr_edge;
  logic        r_irq_p1;
  logic [4:0]  r_irq_id_p1;

  // Stage p0: optional synchroniser; the chain is flushed by rst so edge history restarts cleanly
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_sync = irq_i & IMPL_MASK;
    end else begin : g_sync
      logic [31:0] r_sync_p0 [SYNC_STAGES];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < SYNC_STAGES; i++) r_sync_p0[i] <= '0;
        end else begin
          r_sync_p0[0] <= irq_i & IMPL_MASK;
          for (int i = 1; i < SYNC_STAGES; i++) r_sync_p0[i] <= r_sync_p0[i-1];
        end
      end
      assign w_sync = r_sync_p0[SYNC_STAGES-1];
    end
  endgenerate

  assign w_offset   = spr.spr_addr_i[10:0];
  assign w_wr_picmr = spr.spr_access_i & spr.spr_we_i & (w_offset == OFF_PICMR);
  assign w_wr_picsr = spr.spr_access_i & spr.spr_we_i & (w_offset == OFF_PICSR);
  assign w_clr      = w_wr_picsr ? spr.spr_dat_i : 32'h0;
  assign w_unused   = ^spr.spr_addr_i[15:11];

  always_ff @(posedge clk) begin
    if (rst)
      r_picmr <= NMI_MASK;
    else if (w_wr_picmr)
      r_picmr <= (spr.spr_dat_i | NMI_MASK) & IMPL_MASK;
  end

  // Edge history tracks the synchronised line regardless of mask, so unmasking a
  // line that is already high does not manufacture an edge.
  assign w_edge = w_sync & ~r_edge_hist & r_picmr & EDGE_BITS;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_edge_hist  <= '0;
      r_picsr_edge <= '0;
    end else begin
      r_edge_hist  <= w_sync & EDGE_BITS;
      r_picsr_edge <= ((r_picsr_edge & ~w_clr) | w_edge) & EDGE_BITS;
    end
  end

  assign w_picsr = (w_sync & r_picmr & LEVEL_BITS) | r_picsr_edge;

  // Stage p1: registered interrupt request and vector
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_p1    <= 1'b0;
      r_irq_id_p1 <= '0;
    end else begin
      r_irq_p1    <= |w_picsr;
      r_irq_id_p1 <= lowest_set(w_picsr);
    end
  end

  always_comb begin
    spr.spr_dat_o = '0;
    case (w_offset)
      OFF_PICMR: spr.spr_dat_o = r_picmr;
      OFF_PICID: spr.spr_dat_o = {r_irq_p1, 26'b0, r_irq_id_p1};
      OFF_PICSR: spr.spr_dat_o = w_picsr;
      default:   spr.spr_dat_o = '0;
    endcase
  end

  assign spr.spr_bus_ack = spr.spr_access_i;
  assign spr_picmr_o     = r_picmr;
  assign spr_picsr_o     = w_picsr;
  assign irq_o           = r_irq_p1;
  assign irq_id_o        = r_irq_id_p1;

endmodule

// File: tb/tb_mor1kx_pic_vectored.sv
// Directed bench: DUT A (32 lines, NMI=2, edge lines 3/7/9, 2-stage sync) and
// DUT B (8 lines, no NMI, all level, no synchroniser).
module tb_mor1kx_pic_vectored;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] irq_a, irq_b;
  logic [31:0] picmr_a, picsr_a, picmr_b, picsr_b;
  logic        irqo_a, irqo_b;
  logic [4:0]  id_a, id_b;

  int errors = 0;
  int checks = 0;

  mor1kx_pic_vectored_if spr_a();
  mor1kx_pic_vectored_if spr_b();

  mor1kx_pic_vectored #(
    .NUM_IRQS(32), .OPTION_PIC_NMI_WIDTH(2), .EDGE_MASK(32'h0000_0288), .SYNC_STAGES(2)
  ) u_dut_a (
    .clk(clk), .rst(rst), .irq_i(irq_a), .spr(spr_a),
    .spr_picmr_o(picmr_a), .spr_picsr_o(picsr_a), .irq_o(irqo_a), .irq_id_o(id_a)
  );

  mor1kx_pic_vectored #(
    .NUM_IRQS(8), .OPTION_PIC_NMI_WIDTH(0), .EDGE_MASK(32'h0), .SYNC_STAGES(0)
  ) u_dut_b (
    .clk(clk), .rst(rst), .irq_i(irq_b), .spr(spr_b),
    .spr_picmr_o(picmr_b), .spr_picsr_o(picsr_b), .irq_o(irqo_b), .irq_id_o(id_b)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_a(input logic [10:0] off, input logic [31:0] d);
    spr_a.spr_access_i = 1'b1;
    spr_a.spr_we_i     = 1'b1;
    spr_a.spr_addr_i   = 16'h4800 | {5'b0, off};
    spr_a.spr_dat_i    = d;
    tick();
    spr_a.spr_access_i = 1'b0;
    spr_a.spr_we_i     = 1'b0;
  endtask

  task automatic rd_a(input logic [10:0] off, output logic [31:0] d);
    spr_a.spr_access_i = 1'b1;
    spr_a.spr_we_i     = 1'b0;
    spr_a.spr_addr_i   = 16'h4800 | {5'b0, off};
    #1;
    d = spr_a.spr_dat_o;
    spr_a.spr_access_i = 1'b0;
  endtask

  task automatic wr_b(input logic [10:0] off, input logic [31:0] d);
    spr_b.spr_access_i = 1'b1;
    spr_b.spr_we_i     = 1'b1;
    spr_b.spr_addr_i   = 16'h4800 | {5'b0, off};
    spr_b.spr_dat_i    = d;
    tick();
    spr_b.spr_access_i = 1'b0;
    spr_b.spr_we_i     = 1'b0;
  endtask

  task automatic rd_b(input logic [10:0] off, output logic [31:0] d);
    spr_b.spr_access_i = 1'b1;
    spr_b.spr_we_i     = 1'b0;
    spr_b.spr_addr_i   = 16'h4800 | {5'b0, off};
    #1;
    d = spr_b.spr_dat_o;
    spr_b.spr_access_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    tick(3);
    checks++; if (picmr_a !== 32'h3) begin errors++; $display("FAIL reset_picmr_a got %h want %h", picmr_a, 32'h3); end
    checks++; if (picsr_a !== 32'h0) begin errors++; $display("FAIL reset_picsr_a got %h want %h", picsr_a, 32'h0); end
    checks++; if (irqo_a !== 1'b0 || id_a !== 5'd0) begin errors++; $display("FAIL reset_irq_a got %b/%0d want 0/0", irqo_a, id_a); end
    checks++; if (picmr_b !== 32'h0) begin errors++; $display("FAIL reset_picmr_b got %h want %h", picmr_b, 32'h0); end
    rst = 1'b0;
    tick();
    checks++; if (spr_a.spr_bus_ack !== 1'b0) begin errors++; $display("FAIL ack_idle got %b want 0", spr_a.spr_bus_ack); end
    spr_a.spr_access_i = 1'b1;
    spr_a.spr_addr_i   = 16'h4805;
    #1;
    checks++; if (spr_a.spr_bus_ack !== 1'b1) begin errors++; $display("FAIL ack_access got %b want 1", spr_a.spr_bus_ack); end
    spr_a.spr_access_i = 1'b0;
    rd_a(11'd5, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL read_off5 got %h want %h", d, 32'h0); end
    rd_a(11'd0, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL read_picmr_reset got %h want %h", d, 32'h3); end
  endtask

  task automatic test_level();
    wr_a(11'd0, 32'h10);
    checks++; if (picmr_a !== 32'h13) begin errors++; $display("FAIL level_picmr got %h want %h", picmr_a, 32'h13); end
    wr_a(11'd1, 32'hFFFF_FFFF);
    checks++; if (picmr_a !== 32'h13) begin errors++; $display("FAIL picid_write_ignored got %h want %h", picmr_a, 32'h13); end
    irq_a[4] = 1'b1;
    tick();
    checks++; if (picsr_a !== 32'h0) begin errors++; $display("FAIL level_rise_1clk got %h want %h", picsr_a, 32'h0); end
    tick();
    checks++; if (picsr_a !== 32'h10 || irqo_a !== 1'b0) begin errors++; $display("FAIL level_rise_2clk got %h/%b want 10/0", picsr_a, irqo_a); end
    tick();
    checks++; if (irqo_a !== 1'b1 || id_a !== 5'd4) begin errors++; $display("FAIL level_irq_3clk got %b/%0d want 1/4", irqo_a, id_a); end
    irq_a[4] = 1'b0;
    tick();
    checks++; if (picsr_a !== 32'h10) begin errors++; $display("FAIL level_fall_1clk got %h want %h", picsr_a, 32'h10); end
    tick();
    checks++; if (picsr_a !== 32'h0 || irqo_a !== 1'b1) begin errors++; $display("FAIL level_fall_2clk got %h/%b want 0/1", picsr_a, irqo_a); end
    tick();
    checks++; if (irqo_a !== 1'b0 || id_a !== 5'd0) begin errors++; $display("FAIL level_fall_3clk got %b/%0d want 0/0", irqo_a, id_a); end
  endtask

  task automatic test_edge();
    logic [31:0] d;
    wr_a(11'd0, 32'h298);
    checks++; if (picmr_a !== 32'h29B) begin errors++; $display("FAIL edge_picmr got %h want %h", picmr_a, 32'h29B); end
    irq_a[7] = 1'b1;
    tick();
    irq_a[7] = 1'b0;
    tick();
    checks++; if (picsr_a !== 32'h0) begin errors++; $display("FAIL edge_early got %h want %h", picsr_a, 32'h0); end
    tick();
    checks++; if (picsr_a !== 32'h80) begin errors++; $display("FAIL edge_set got %h want %h", picsr_a, 32'h80); end
    tick(4);
    checks++; if (picsr_a !== 32'h80) begin errors++; $display("FAIL edge_sticky got %h want %h", picsr_a, 32'h80); end
    checks++; if (irqo_a !== 1'b1 || id_a !== 5'd7) begin errors++; $display("FAIL edge_irq got %b/%0d want 1/7", irqo_a, id_a); end
    rd_a(11'd2, d);
    checks++; if (d !== 32'h80) begin errors++; $display("FAIL edge_read_picsr got %h want %h", d, 32'h80); end
    wr_a(11'd2, 32'h80);
    checks++; if (picsr_a !== 32'h0) begin errors++; $display("FAIL edge_w1c got %h want %h", picsr_a, 32'h0); end
    tick();
    checks++; if (irqo_a !== 1'b0) begin errors++; $display("FAIL edge_irq_drop got %b want 0", irqo_a); end
    irq_a[7] = 1'b1;
    tick();
    irq_a[7] = 1'b0;
    tick();
    wr_a(11'd2, 32'h80);
    checks++; if (picsr_a !== 32'h80) begin errors++; $display("FAIL edge_set_wins got %h want %h", picsr_a, 32'h80); end
    wr_a(11'd0, 32'h218);
    checks++; if (picsr_a !== 32'h80) begin errors++; $display("FAIL edge_mask_keeps got %h want %h", picsr_a, 32'h80); end
    wr_a(11'd2, 32'h80);
    checks++; if (picsr_a !== 32'h0) begin errors++; $display("FAIL edge_clear2 got %h want %h", picsr_a, 32'h0); end
    wr_a(11'd0, 32'h298);
  endtask

  task automatic test_priority();
    logic [31:0] d;
    irq_a = 32'h208;
    tick();
    irq_a = 32'h0;
    tick(4);
    checks++; if (picsr_a !== 32'h208 || id_a !== 5'd3) begin errors++; $display("FAIL prio_both got %h/%0d want 208/3", picsr_a, id_a); end
    wr_a(11'd2, 32'h8);
    checks++; if (picsr_a !== 32'h200 || id_a !== 5'd3) begin errors++; $display("FAIL prio_clear3 got %h/%0d want 200/3", picsr_a, id_a); end
    tick();
    checks++; if (id_a !== 5'd9 || irqo_a !== 1'b1) begin errors++; $display("FAIL prio_next got %0d/%b want 9/1", id_a, irqo_a); end
    rd_a(11'd1, d);
    checks++; if (d !== 32'h8000_0009) begin errors++; $display("FAIL picid_read got %h want %h", d, 32'h8000_0009); end
    wr_a(11'd2, 32'h200);
    tick();
    rd_a(11'd1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL picid_idle got %h want %h", d, 32'h0); end
  endtask

  task automatic test_num_irqs();
    logic [31:0] d;
    wr_b(11'd0, 32'hFFFF_FFFF);
    checks++; if (picmr_b !== 32'hFF) begin errors++; $display("FAIL b_picmr got %h want %h", picmr_b, 32'hFF); end
    rd_b(11'd0, d);
    checks++; if (d !== 32'hFF) begin errors++; $display("FAIL b_read_picmr got %h want %h", d, 32'hFF); end
    irq_b = 32'h0010_0000;
    tick();
    irq_b = 32'h0;
    tick();
    irq_b = 32'h0010_0000;
    tick();
    checks++; if (picsr_b !== 32'h0 || irqo_b !== 1'b0) begin errors++; $display("FAIL b_irq20 got %h/%b want 0/0", picsr_b, irqo_b); end
    irq_b = 32'h0010_0020;
    #1;
    checks++; if (picsr_b !== 32'h20) begin errors++; $display("FAIL b_nosync_level got %h want %h", picsr_b, 32'h20); end
    tick();
    checks++; if (irqo_b !== 1'b1 || id_b !== 5'd5) begin errors++; $display("FAIL b_irq5 got %b/%0d want 1/5", irqo_b, id_b); end
    irq_b = 32'h0;
    tick();
  endtask

  task automatic test_reset_midop();
    irq_a[7] = 1'b1;
    tick(4);
    checks++; if (picsr_a !== 32'h80) begin errors++; $display("FAIL rst_pre_pending got %h want %h", picsr_a, 32'h80); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (picsr_a !== 32'h0 || picmr_a !== 32'h3 || irqo_a !== 1'b0) begin errors++; $display("FAIL rst_mid got %h/%h/%b want 0/3/0", picsr_a, picmr_a, irqo_a); end
    tick(4);
    wr_a(11'd0, 32'h298);
    tick(4);
    checks++; if (picsr_a !== 32'h0) begin errors++; $display("FAIL rst_held_no_edge got %h want %h", picsr_a, 32'h0); end
    irq_a[7] = 1'b0;
    tick(4);
    irq_a[7] = 1'b1;
    tick(4);
    checks++; if (picsr_a !== 32'h80) begin errors++; $display("FAIL rst_new_edge got %h want %h", picsr_a, 32'h80); end
    irq_a[7] = 1'b0;
    wr_a(11'd2, 32'h80);
  endtask

  initial begin
    irq_a = '0;
    irq_b = '0;
    spr_a.spr_access_i = 1'b0; spr_a.spr_we_i = 1'b0; spr_a.spr_addr_i = '0; spr_a.spr_dat_i = '0;
    spr_b.spr_access_i = 1'b0; spr_b.spr_we_i = 1'b0; spr_b.spr_addr_i = '0; spr_b.spr_dat_i = '0;
    test_reset();
    test_level();
    test_edge();
    test_priority();
    test_num_irqs();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
